// File: rtl/ext_data_seq.sv
`default_nettype none
// ============================================================================
// Module   : ext_data_seq
// Purpose  : Program/stimulus sequencer for the RISCV16bit core ext_data bus.
//            Plays words from a loadable internal memory onto ext_data using
//            a valid/ready handshake. Supports single-pass, loop and
//            single-step playback. Also keeps an unsigned min/max/count of
//            the results the core returns on OutR.
// Ports    : clk, rst                        - clock, sync active-high reset
//            load_we/load_addr/load_data     - program write port (IDLE only)
//            length, mode, start             - playback setup, sampled on start
//            abort, step                     - playback control
//            ext_data, ext_valid, ext_ready  - word handshake towards the core
//            result_in, result_valid         - result stream from the core
//            res_min, res_max, res_count     - result statistics since start
//            busy, done                      - status
// Revision : 1.0 - initial release
// ============================================================================
module ext_data_seq #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W:0]   length,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              abort,
    input  logic              step,
    output logic [DATA_W-1:0] ext_data,
    output logic              ext_valid,
    input  logic              ext_ready,
    input  logic [DATA_W-1:0] result_in,
    input  logic              result_valid,
    output logic [DATA_W-1:0] res_min,
    output logic [DATA_W-1:0] res_max,
    output logic [7:0]        res_count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_PRESENT   = 3'd2,
        S_WAIT_STEP = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_LOOP   = 2'b01;
    localparam logic [1:0] MODE_STEP   = 2'b10;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   ext_data_q, ext_data_d;
    logic [DATA_W-1:0]   res_min_q, res_min_d;
    logic [DATA_W-1:0]   res_max_q, res_max_d;
    logic [7:0]          res_count_q, res_count_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                start_go;
    logic                last_word;

    assign start_go  = (state_q == S_IDLE) && start;
    // Compare at ADDR_W+1 bits so length == DEPTH is handled without overflow.
    assign last_word = ({1'b0, index_q} == (len_q - (ADDR_W + 1)'(1)));

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        len_d      = len_q;
        mode_d     = mode_q;
        ext_data_d = ext_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = length;
                    // Reserved encoding 11 behaves as single-pass.
                    mode_d  = (mode == 2'b11) ? MODE_SINGLE : mode;
                    index_d = '0;
                    if (length == '0) begin
                        state_d = S_FINISH;
                    end else if (mode == MODE_STEP) begin
                        state_d = S_WAIT_STEP;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                ext_data_d = mem[index_q];
                state_d    = S_PRESENT;
            end
            S_PRESENT: begin
                if (ext_ready) begin
                    if (last_word) begin
                        index_d = '0;
                        state_d = (mode_q == MODE_LOOP) ? S_FETCH : S_FINISH;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                        state_d = (mode_q == MODE_STEP) ? S_WAIT_STEP : S_FETCH;
                    end
                end
            end
            S_WAIT_STEP: begin
                if (step) begin
                    state_d = S_FETCH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides accept/step in every active state.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            index_d = index_q;
        end
    end

    // ------------------------------------------------------------------
    // Result statistics: a start clears them and drops any coincident sample
    // ------------------------------------------------------------------
    always_comb begin
        res_min_d   = res_min_q;
        res_max_d   = res_max_q;
        res_count_d = res_count_q;
        if (start_go) begin
            res_min_d   = '1;
            res_max_d   = '0;
            res_count_d = '0;
        end else if (result_valid) begin
            if (result_in < res_min_q) begin
                res_min_d = result_in;
            end
            if (result_in > res_max_q) begin
                res_max_d = result_in;
            end
            if (res_count_q != 8'hFF) begin
                res_count_d = res_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            len_q       <= '0;
            mode_q      <= MODE_SINGLE;
            ext_data_q  <= '0;
            res_min_q   <= '1;
            res_max_q   <= '0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            ext_data_q  <= ext_data_d;
            res_min_q   <= res_min_d;
            res_max_q   <= res_max_d;
            res_count_q <= res_count_d;
        end
    end

    // Program memory has no reset; writes are only honoured while idle.
    always_ff @(posedge clk) begin
        if (!rst && load_we && (state_q == S_IDLE)) begin
            mem[load_addr] <= load_data;
        end
    end

    assign ext_data  = ext_data_q;
    assign ext_valid = (state_q == S_PRESENT);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign res_min   = res_min_q;
    assign res_max   = res_max_q;
    assign res_count = res_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ext_data_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_data_seq
// Purpose  : Self-checking bench for ext_data_seq. A transaction-level model
//            holds the expected program and the result statistics; accepted
//            words are collected and compared against the program order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_data_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_we;
    logic [3:0]  load_addr;
    logic [15:0] load_data;
    logic [4:0]  length;
    logic [1:0]  mode;
    logic        start;
    logic        abort;
    logic        step;
    logic [15:0] ext_data;
    logic        ext_valid;
    logic        ext_ready;
    logic [15:0] result_in;
    logic        result_valid;
    logic [15:0] res_min;
    logic [15:0] res_max;
    logic [7:0]  res_count;
    logic        busy;
    logic        done;

    ext_data_seq #(.DATA_W(16), .DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .length(length), .mode(mode), .start(start), .abort(abort), .step(step),
        .ext_data(ext_data), .ext_valid(ext_valid), .ext_ready(ext_ready),
        .result_in(result_in), .result_valid(result_valid),
        .res_min(res_min), .res_max(res_max), .res_count(res_count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors  = 0;
    logic [15:0] m_mem [16];
    logic [15:0] m_min = 16'hFFFF;
    logic [15:0] m_max = 16'h0000;
    int          m_cnt = 0;
    logic [15:0] got [$];
    int          acc_cyc [$];
    int          cyc = 0;
    int          done_cnt = 0;
    bit          saw_valid = 1'b0;
    bit          rand_res = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: sample handshake before the edge, update the model, step.
    task automatic tick();
        bit          acc;
        logic [15:0] w;
        if (rand_res) begin
            result_valid = 1'($urandom_range(0, 1));
            result_in    = 16'($urandom);
        end
        acc = ext_valid && ext_ready;
        w   = ext_data;
        if (rst || start) begin
            m_min = 16'hFFFF; m_max = 16'h0000; m_cnt = 0;
        end else if (result_valid) begin
            if (result_in < m_min) m_min = result_in;
            if (result_in > m_max) m_max = result_in;
            if (m_cnt < 255) m_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            got.push_back(w);
            acc_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
        if (ext_valid) saw_valid = 1'b1;
        if (rand_res) begin
            check_eq("res_min_track", 32'(res_min), 32'(m_min));
            check_eq("res_max_track", 32'(res_max), 32'(m_max));
            check_eq("res_cnt_track", 32'(res_count), 32'(m_cnt));
        end
    endtask

    task automatic clear_mon();
        got.delete();
        acc_cyc.delete();
        done_cnt  = 0;
        saw_valid = 1'b0;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [15:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        tick();
        load_we = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic do_start(input int len, input logic [1:0] md);
        length = 5'(len); mode = md; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input bit rnd_ready);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            if (rnd_ready) ext_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check_eq("done_within_budget", 32'(done_cnt > 0), 32'd1);
    endtask

    // Accepted words must follow program order, wrapping every 'wrap' words.
    task automatic check_seq(input string tag, input int n, input int wrap, input bit exact);
        if (exact) check_eq({tag, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < got.size() && i < n; i++)
            check_eq(tag, 32'(got[i]), 32'(m_mem[i % wrap]));
    endtask

    initial begin
        int n;
        int len;
        logic [1:0] md;
        rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
        length = '0; mode = '0; start = 1'b0; abort = 1'b0; step = 1'b0;
        ext_ready = 1'b0; result_in = '0; result_valid = 1'b0;
        repeat (3) tick();
        check_eq("rst_ext_valid", 32'(ext_valid), 32'd0);
        check_eq("rst_ext_data", 32'(ext_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_res_min", 32'(res_min), 32'hFFFF);
        check_eq("rst_res_max", 32'(res_max), 32'd0);
        check_eq("rst_res_count", 32'(res_count), 32'd0);
        rst = 1'b0;
        tick();

        // ---- single pass, ready always high
        for (int i = 0; i < 16; i++) load_word(4'(i), 16'($urandom));
        load_word(4'd0, 16'h0001); load_word(4'd1, 16'h0002);
        load_word(4'd2, 16'h0010); load_word(4'd3, 16'h0011);
        clear_mon(); ext_ready = 1'b1;
        do_start(4, 2'b00);
        check_eq("t1_fetch_valid", 32'(ext_valid), 32'd0);
        check_eq("t1_fetch_busy", 32'(busy), 32'd1);
        tick();
        check_eq("t1_first_valid", 32'(ext_valid), 32'd1);
        check_eq("t1_first_data", 32'(ext_data), 32'h0001);
        run_until_done(50, 1'b0);
        check_seq("t1_word", 4, 4, 1'b1);
        if (acc_cyc.size() == 4)
            for (int i = 1; i < 4; i++)
                check_eq("t1_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
        tick();
        check_eq("t1_busy_after", 32'(busy), 32'd0);
        check_eq("t1_done_once", 32'(done_cnt), 32'd1);

        // ---- stall on word 0002
        clear_mon(); ext_ready = 1'b1;
        do_start(4, 2'b00);
        tick();
        tick();
        ext_ready = 1'b0;
        tick();
        repeat (5) begin
            tick();
            check_eq("t2_stall_valid", 32'(ext_valid), 32'd1);
            check_eq("t2_stall_data", 32'(ext_data), 32'h0002);
        end
        ext_ready = 1'b1;
        run_until_done(50, 1'b0);
        check_seq("t2_word", 4, 4, 1'b1);
        tick();

        // ---- loop mode then abort mid-PRESENT
        clear_mon(); ext_ready = 1'b1;
        do_start(3, 2'b01);
        n = 0;
        while (got.size() < 7 && n < 100) begin tick(); n++; end
        check_eq("t3_loop_progress", 32'(got.size() >= 7), 32'd1);
        ext_ready = 1'b0;
        n = 0;
        while (!ext_valid && n < 10) begin tick(); n++; end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("t3_abort_valid", 32'(ext_valid), 32'd0);
        check_eq("t3_abort_busy", 32'(busy), 32'd0);
        tick();
        check_eq("t3_no_done", 32'(done_cnt), 32'd0);
        check_seq("t3_loop_word", got.size(), 3, 1'b0);

        // ---- step mode, extra step during PRESENT must be ignored
        clear_mon(); ext_ready = 1'b0;
        do_start(2, 2'b10);
        for (int w = 0; w < 2; w++) begin
            repeat (9) begin
                tick();
                check_eq("t4_wait_valid", 32'(ext_valid), 32'd0);
            end
            step = 1'b1; tick(); step = 1'b0;
            tick();
            check_eq("t4_present_data", 32'(ext_data), 32'(m_mem[w]));
            step = 1'b1; tick(); step = 1'b0;
            check_eq("t4_held_valid", 32'(ext_valid), 32'd1);
            ext_ready = 1'b1; tick(); ext_ready = 1'b0;
        end
        check_eq("t4_done", 32'(done), 32'd1);
        tick();
        check_eq("t4_busy_after", 32'(busy), 32'd0);
        check_eq("t4_done_once", 32'(done_cnt), 32'd1);
        check_seq("t4_word", 2, 2, 1'b1);

        // ---- length 0
        clear_mon();
        do_start(0, 2'b00);
        check_eq("t5_done", 32'(done), 32'd1);
        tick();
        check_eq("t5_busy_after", 32'(busy), 32'd0);
        check_eq("t5_never_valid", 32'(saw_valid), 32'd0);

        // ---- writes while busy are dropped (m_mem deliberately untouched)
        clear_mon(); ext_ready = 1'b0;
        do_start(4, 2'b00);
        load_we = 1'b1; load_addr = 4'd0; load_data = 16'hBEEF; tick();
        load_addr = 4'd2; load_data = 16'hCAFE; tick();
        load_we = 1'b0;
        ext_ready = 1'b1;
        run_until_done(50, 1'b0);
        tick();
        clear_mon();
        do_start(4, 2'b00);
        run_until_done(50, 1'b0);
        check_seq("t5_replay", 4, 4, 1'b1);
        tick();

        // ---- result tracker
        result_valid = 1'b1; result_in = 16'h0001;
        do_start(0, 2'b00);
        result_valid = 1'b0;
        check_eq("t6_start_drop_cnt", 32'(res_count), 32'd0);
        check_eq("t6_start_drop_min", 32'(res_min), 32'hFFFF);
        tick();
        result_valid = 1'b1;
        result_in = 16'h0005; tick();
        check_eq("t6_first_min", 32'(res_min), 32'h0005);
        check_eq("t6_first_max", 32'(res_max), 32'h0005);
        result_in = 16'hFFFF; tick();
        result_in = 16'h0000; tick();
        for (int i = 0; i < 300; i++) begin
            result_in = 16'($urandom);
            tick();
        end
        result_valid = 1'b0;
        check_eq("t6_min", 32'(res_min), 32'h0000);
        check_eq("t6_max", 32'(res_max), 32'hFFFF);
        check_eq("t6_count_sat", 32'(res_count), 32'd255);
        do_start(0, 2'b00);
        check_eq("t6_clr_min", 32'(res_min), 32'hFFFF);
        check_eq("t6_clr_max", 32'(res_max), 32'h0000);
        check_eq("t6_clr_count", 32'(res_count), 32'd0);
        tick();

        // ---- randomized programs, modes and handshakes
        rand_res = 1'b1;
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < 16; i++) load_word(4'(i), 16'($urandom));
            len = $urandom_range(0, 16);
            case ($urandom_range(0, 2))
                0: md = 2'b00;
                1: md = 2'b01;
                default: md = 2'b11;
            endcase
            clear_mon();
            do_start(len, md);
            if (md == 2'b01 && len > 0) begin
                n = 0;
                while (got.size() < len + 3 && n < 400) begin
                    ext_ready = 1'($urandom_range(0, 1));
                    tick();
                    n++;
                end
                ext_ready = 1'b0;
                n = 0;
                while (!ext_valid && n < 10) begin tick(); n++; end
                abort = 1'b1; tick(); abort = 1'b0;
                check_eq("rnd_abort_busy", 32'(busy), 32'd0);
                check_eq("rnd_loop_no_done", 32'(done_cnt), 32'd0);
                check_seq("rnd_loop_word", got.size(), len, 1'b0);
            end else begin
                run_until_done(400, 1'b1);
                tick();
                check_eq("rnd_busy_after", 32'(busy), 32'd0);
                check_eq("rnd_done_once", 32'(done_cnt), 32'd1);
                check_seq("rnd_word", len, (len == 0) ? 1 : len, 1'b1);
            end
        end
        rand_res = 1'b0;
        result_valid = 1'b0;

        // ---- reset in the middle of a handshake
        clear_mon(); ext_ready = 1'b0;
        do_start(4, 2'b00);
        tick();
        result_valid = 1'b1; result_in = 16'h0042; tick(); result_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("t8_rst_valid", 32'(ext_valid), 32'd0);
        check_eq("t8_rst_busy", 32'(busy), 32'd0);
        check_eq("t8_rst_count", 32'(res_count), 32'd0);
        check_eq("t8_rst_min", 32'(res_min), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
